// File: rtl/cc_lose_scanner.sv
// Lose-comparator sequencer: walks the matrix rows each frame tick, feeds row
// pairs to the external comparator through a one-cycle operand register, ORs
// the per-row results into a frame hit, and declares LOSE after CONFIRM
// consecutive hit frames.
module cc_lose_scanner #(
  parameter int ROWS    = 8,
  parameter int WIDTH   = 8,
  parameter int CONFIRM = 2
) (
  input  logic                    CC_LOSE_SCANNER_CLOCK_50,
  input  logic                    CC_LOSE_SCANNER_RESET_InHigh,
  input  logic                    CC_LOSE_SCANNER_enable_In,
  input  logic                    CC_LOSE_SCANNER_frameTick_In,
  input  logic                    CC_LOSE_SCANNER_clear_In,
  output logic [$clog2(ROWS)-1:0] CC_LOSE_SCANNER_rowSel_Out,
  input  logic [WIDTH-1:0]        CC_LOSE_SCANNER_joinedRow_In,
  input  logic [WIDTH-1:0]        CC_LOSE_SCANNER_normRow_In,
  output logic [WIDTH-1:0]        CC_LOSE_SCANNER_BusJoined_Out,
  output logic [WIDTH-1:0]        CC_LOSE_SCANNER_BusNorm_Out,
  input  logic                    CC_LOSE_SCANNER_loseout_In,
  output logic                    CC_LOSE_SCANNER_busy_Out,
  output logic                    CC_LOSE_SCANNER_lose_Out,
  output logic [$clog2(ROWS)-1:0] CC_LOSE_SCANNER_hitRow_Out
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam int HW = $clog2(CONFIRM + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, LOSE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          frame_hit;
  logic [RW-1:0] frame_row;
  logic [HW-1:0] hit_count;
  logic [HW-1:0] hit_count_inc;
  logic          row_valid;
  logic          scan_last;
  logic          start;
  logic          reach;

  wire clk = CC_LOSE_SCANNER_CLOCK_50;
  wire rst = CC_LOSE_SCANNER_RESET_InHigh;
  wire en  = CC_LOSE_SCANNER_enable_In;
  wire clr = CC_LOSE_SCANNER_clear_In;

  assign row_valid     = (cnt < CW'(ROWS));
  assign scan_last     = (cnt == CW'(ROWS));
  assign start         = en && CC_LOSE_SCANNER_frameTick_In;
  assign hit_count_inc = (hit_count == HW'(CONFIRM)) ? hit_count : hit_count + HW'(1);
  assign reach         = (hit_count_inc == HW'(CONFIRM));

  assign CC_LOSE_SCANNER_rowSel_Out = row_valid ? RW'(cnt) : LAST_ROW;
  assign CC_LOSE_SCANNER_busy_Out   = (state == SCAN) || (state == EVAL);
  assign CC_LOSE_SCANNER_lose_Out   = (state == LOSE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; enable-low aborts a frame, clear beats a confirming EVAL.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        if (!en)            state_next = IDLE;
        else if (scan_last) state_next = EVAL;
      end
      EVAL: begin
        if (en && !clr && frame_hit && reach) state_next = LOSE;
        else                                  state_next = IDLE;
      end
      LOSE: if (clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan datapath: row counter, operand registers, frame hit capture, hit row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                           <= '0;
      frame_hit                     <= 1'b0;
      frame_row                     <= '0;
      CC_LOSE_SCANNER_BusJoined_Out <= '0;
      CC_LOSE_SCANNER_BusNorm_Out   <= '0;
      CC_LOSE_SCANNER_hitRow_Out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            frame_hit <= 1'b0;
          end
        end
        SCAN: begin
          if (en) begin
            if (row_valid) begin
              CC_LOSE_SCANNER_BusJoined_Out <= CC_LOSE_SCANNER_joinedRow_In;
              CC_LOSE_SCANNER_BusNorm_Out   <= CC_LOSE_SCANNER_normRow_In;
            end
            // Comparator output this cycle belongs to the row registered last cycle.
            if ((cnt != '0) && CC_LOSE_SCANNER_loseout_In) begin
              frame_hit <= 1'b1;
              if (!frame_hit) frame_row <= RW'(cnt - CW'(1));
            end
            if (!scan_last) cnt <= cnt + CW'(1);
          end
        end
        EVAL: begin
          if (en && !clr && frame_hit && reach) CC_LOSE_SCANNER_hitRow_Out <= frame_row;
        end
        default: ;
      endcase
    end
  end

  // Consecutive hit-frame counter, saturating at CONFIRM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
    end else begin
      unique case (state)
        IDLE: if (clr) hit_count <= '0;
        SCAN: if (clr || !en) hit_count <= '0;
        EVAL: begin
          if (clr || !en || !frame_hit) hit_count <= '0;
          else                          hit_count <= hit_count_inc;
        end
        LOSE: if (clr) hit_count <= '0;
        default: hit_count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_lose_scanner.sv
// Directed bench for cc_lose_scanner with a behavioural matrix and comparator.
module tb_cc_lose_scanner;

  localparam int ROWS  = 8;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             frame_tick = 1'b0;
  logic             clear = 1'b0;
  logic [2:0]       row_sel;
  logic [WIDTH-1:0] joined_row, norm_row;
  logic [WIDTH-1:0] bus_joined, bus_norm;
  logic             loseout;
  logic             busy, lose;
  logic [2:0]       hit_row;

  logic [WIDTH-1:0] joined_mem [ROWS];
  logic [WIDTH-1:0] norm_mem   [ROWS];

  int errors = 0;
  int checks = 0;

  assign joined_row = joined_mem[row_sel];
  assign norm_row   = norm_mem[row_sel];
  assign loseout    = (bus_joined >= bus_norm);

  always #5 clk = ~clk;

  cc_lose_scanner #(.ROWS(ROWS), .WIDTH(WIDTH), .CONFIRM(2)) dut (
    .CC_LOSE_SCANNER_CLOCK_50     (clk),
    .CC_LOSE_SCANNER_RESET_InHigh (rst),
    .CC_LOSE_SCANNER_enable_In    (enable),
    .CC_LOSE_SCANNER_frameTick_In (frame_tick),
    .CC_LOSE_SCANNER_clear_In     (clear),
    .CC_LOSE_SCANNER_rowSel_Out   (row_sel),
    .CC_LOSE_SCANNER_joinedRow_In (joined_row),
    .CC_LOSE_SCANNER_normRow_In   (norm_row),
    .CC_LOSE_SCANNER_BusJoined_Out(bus_joined),
    .CC_LOSE_SCANNER_BusNorm_Out  (bus_norm),
    .CC_LOSE_SCANNER_loseout_In   (loseout),
    .CC_LOSE_SCANNER_busy_Out     (busy),
    .CC_LOSE_SCANNER_lose_Out     (lose),
    .CC_LOSE_SCANNER_hitRow_Out   (hit_row)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean_rows();
    for (int r = 0; r < ROWS; r++) begin
      joined_mem[r] = 8'h10;
      norm_mem[r]   = 8'h20;
    end
  endtask

  // One frame: tick sampled at edge 0, cycle c observed #1 after edge c.
  // extra_tick_at > 0 pulses a second tick while the scan is in progress.
  task automatic do_frame(input string tag, input logic exp_lose, input int extra_tick_at = 0);
    frame_tick = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      frame_tick = (c == extra_tick_at);
      if (c <= 8)  check({tag, " rowSel"}, 32'(row_sel), 32'(c - 1));
      if (c == 9)  check({tag, " rowSel hold"}, 32'(row_sel), 32'd7);
      if (c <= 10) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " lose early"}, 32'(lose), 32'd0);
      end
    end
    frame_tick = 1'b0;
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " lose"}, 32'(lose), 32'(exp_lose));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear lose", 32'(lose), 32'd0);
  endtask

  initial begin
    clean_rows();
    step(2);
    check("rst rowSel", 32'(row_sel), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst lose", 32'(lose), 32'd0);
    check("rst hitRow", 32'(hit_row), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    step(2);

    // 1: reset in the middle of a scan.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(4);
    check("t1 rowSel row4", 32'(row_sel), 32'd4);
    check("t1 busJoined pre", 32'(bus_joined), 32'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t1 rowSel", 32'(row_sel), 32'd0);
    check("t1 busy", 32'(busy), 32'd0);
    check("t1 lose", 32'(lose), 32'd0);
    check("t1 busJoined", 32'(bus_joined), 32'd0);
    check("t1 busNorm", 32'(bus_norm), 32'd0);
    check("t1 hitRow", 32'(hit_row), 32'd0);
    step(2);
    do_frame("t1 rescan", 1'b0);
    step(2);

    // 2: no hit rows over three frames.
    for (int f = 0; f < 3; f++) begin
      do_frame("t2", 1'b0);
      step(3);
    end

    // 3: row 5 hits for two frames.
    joined_mem[5] = 8'h40;
    do_frame("t3 f1", 1'b0);
    step(2);
    do_frame("t3 f2", 1'b1);
    check("t3 hitRow", 32'(hit_row), 32'd5);
    check("t3 busJoined hold", 32'(bus_joined), 32'h10);
    check("t3 busNorm hold", 32'(bus_norm), 32'h20);
    do_clear();
    step(2);

    // 4: hit, clean, hit must not lose; a following hit frame does.
    do_frame("t4 f1", 1'b0);
    step(2);
    joined_mem[5] = 8'h10;
    do_frame("t4 f2", 1'b0);
    step(2);
    joined_mem[5] = 8'h40;
    do_frame("t4 f3", 1'b0);
    step(2);
    do_frame("t4 f4", 1'b1);
    do_clear();
    step(2);

    // 5: rows 2 and 6 hit; lowest row reported, ticks ignored in LOSE.
    clean_rows();
    joined_mem[2] = 8'h20;
    joined_mem[6] = 8'hFF;
    do_frame("t5 f1", 1'b0);
    step(2);
    do_frame("t5 f2", 1'b1);
    check("t5 hitRow", 32'(hit_row), 32'd2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(3);
    check("t5 lose held", 32'(lose), 32'd1);
    check("t5 busy in lose", 32'(busy), 32'd0);
    clear = 1'b1;
    frame_tick = 1'b1;
    step();
    clear = 1'b0;
    frame_tick = 1'b0;
    check("t5 clear+tick lose", 32'(lose), 32'd0);
    check("t5 clear+tick busy", 32'(busy), 32'd0);
    step();
    check("t5 tick not queued", 32'(busy), 32'd0);
    step(2);

    // 6: enable drop aborts the confirming frame; tick during SCAN is dropped.
    do_frame("t6 f1", 1'b0);
    step(2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(3);
    check("t6 rowSel row3", 32'(row_sel), 32'd3);
    enable = 1'b0;
    step();
    check("t6 abort busy", 32'(busy), 32'd0);
    check("t6 abort lose", 32'(lose), 32'd0);
    enable = 1'b1;
    step(2);
    do_frame("t6 f3", 1'b0, 3);
    step();
    check("t6 no rescan", 32'(busy), 32'd0);
    step(2);
    do_frame("t6 f4", 1'b1);
    check("t6 hitRow", 32'(hit_row), 32'd2);
    do_clear();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
